maze_move_ctrl: RTL and testbench

Parametrised successor to the maze game's fixed-size controller FSM. Each timer tick it erases the player sprite, consumes one direction key, checks the target cell against obstacle memory through a latency-configurable read port, updates position, tests for the goal and redraws. It sits between the keyboard decoder, the obstacle ROM and the VGA pixel writer.

---
 rtl/maze_move_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_maze_move_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_move_ctrl.sv
// rtl/maze_move_ctrl.sv - maze game step controller: erase, key, obstacle lookup, move, win test, redraw
//
// Optional feature macro: MAZE_WRAP_EN (off-grid moves wrap to the opposite edge
// instead of being rejected).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   key_valid, key_dir  pending direction key (1 left, 2 right, 3 up, 4 down)
//   key_ack             one-cycle pulse when the key has been consumed
//   obs_rd, obs_x/y     obstacle read strobe and queried cell
//   obs_blocked         obstacle reply, valid MEM_LAT cycles after obs_rd
//   goal_x/y            win cell
//   xpos/ypos           current player cell
//   pix_x/y, pix_color  pixel write address and colour (0 erase, 1 draw)
//   plot                pixel write enable
//   moves               accepted moves, saturating
//   won                 sticky goal-reached flag
module maze_move_ctrl #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int SPRITE  = 4,
  parameter int TICKS   = 833333,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_valid,
  input  logic [2:0]     key_dir,
  output logic           key_ack,
  output logic           obs_rd,
  output logic [X_W-1:0] obs_x,
  output logic [Y_W-1:0] obs_y,
  input  logic           obs_blocked,
  input  logic [X_W-1:0] goal_x,
  input  logic [Y_W-1:0] goal_y,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_color,
  output logic           plot,
  output logic [15:0]    moves,
  output logic           won
);

  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_WAIT_TICK  = 4'd1;
  localparam logic [3:0] S_ERASE      = 4'd2;
  localparam logic [3:0] S_READ_KEY   = 4'd3;
  localparam logic [3:0] S_LOOK       = 4'd4;
  localparam logic [3:0] S_WAIT_OBS   = 4'd5;
  localparam logic [3:0] S_UPDATE_POS = 4'd6;
  localparam logic [3:0] S_CHECK_WIN  = 4'd7;
  localparam logic [3:0] S_DRAW       = 4'd8;
  localparam logic [3:0] S_WIN        = 4'd9;

  localparam int             OW        = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam logic [OW-1:0]  S_LAST    = OW'(SPRITE - 1);
  localparam logic [OW-1:0]  OFF_ONE   = OW'(1);
  localparam logic [X_W:0]   X_MAX_E   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_MAX_E   = (Y_W+1)'(Y_MAX);
  localparam logic [X_W:0]   X_ONE     = (X_W+1)'(1);
  localparam logic [Y_W:0]   Y_ONE     = (Y_W+1)'(1);
  localparam logic [X_W-1:0] START_XV  = X_W'(START_X);
  localparam logic [Y_W-1:0] START_YV  = Y_W'(START_Y);
  localparam logic [31:0]    TICK_LAST = 32'(TICKS - 1);
  localparam logic [15:0]    WAIT_LAST = 16'(MEM_LAT - 1);

  logic [3:0]     state;
  logic [31:0]    tick_cnt;
  logic [15:0]    wait_cnt;
  logic [OW-1:0]  col, row;
  logic [X_W-1:0] tgt_x;
  logic [Y_W-1:0] tgt_y;
  logic           tgt_ok;

  logic [X_W:0]   nx;
  logic [Y_W:0]   ny;
  logic           key_ok, off, scan_last, wait_done, go_draw;
  logic [OW-1:0]  col_nx, row_nx;

  // Target is computed one bit wider so that 0-1 and X_MAX+1 both land above
  // the legal range and are caught by a single compare.
  always_comb begin
    nx     = {1'b0, xpos};
    ny     = {1'b0, ypos};
    key_ok = key_valid && (key_dir >= 3'd1) && (key_dir <= 3'd4);
    case (key_dir)
      3'd1:    nx = {1'b0, xpos} - X_ONE;
      3'd2:    nx = {1'b0, xpos} + X_ONE;
      3'd3:    ny = {1'b0, ypos} - Y_ONE;
      3'd4:    ny = {1'b0, ypos} + Y_ONE;
      default: ;
    endcase
    off = (nx > X_MAX_E) || (ny > Y_MAX_E);
`ifdef MAZE_WRAP_EN
    if (nx > X_MAX_E) nx = (key_dir == 3'd1) ? X_MAX_E : '0;
    if (ny > Y_MAX_E) ny = (key_dir == 3'd3) ? Y_MAX_E : '0;
    off = 1'b0;
`endif
  end

  always_comb begin
    scan_last = (col == S_LAST) && (row == S_LAST);
    col_nx    = (col == S_LAST) ? '0 : col + OFF_ONE;
    row_nx    = (col == S_LAST) ? row + OFF_ONE : row;
    wait_done = (wait_cnt == WAIT_LAST);
    go_draw   = ((state == S_READ_KEY) && !key_ok) ||
                ((state == S_LOOK) && !tgt_ok) ||
                ((state == S_WAIT_OBS) && wait_done && obs_blocked) ||
                (state == S_CHECK_WIN);
  end

  // The key target is resolved in READ_KEY so the read strobe is already on the
  // port during LOOK; the reply is then sampled on the last of MEM_LAT WAIT_OBS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      xpos      <= START_XV;
      ypos      <= START_YV;
      moves     <= '0;
      won       <= 1'b0;
      plot      <= 1'b0;
      pix_color <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      key_ack   <= 1'b0;
      obs_rd    <= 1'b0;
      obs_x     <= '0;
      obs_y     <= '0;
      tick_cnt  <= '0;
      wait_cnt  <= '0;
      col       <= '0;
      row       <= '0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      tgt_ok    <= 1'b0;
    end else begin
      key_ack <= 1'b0;
      obs_rd  <= 1'b0;
      case (state)
        S_INIT: begin
          xpos      <= START_XV;
          ypos      <= START_YV;
          moves     <= '0;
          won       <= 1'b0;
          tick_cnt  <= '0;
          state     <= S_DRAW;
          plot      <= 1'b1;
          pix_color <= 1'b1;
          pix_x     <= START_XV;
          pix_y     <= START_YV;
          col       <= '0;
          row       <= '0;
        end
        S_WAIT_TICK: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= '0;
            state     <= S_ERASE;
            plot      <= 1'b1;
            pix_color <= 1'b0;
            pix_x     <= xpos;
            pix_y     <= ypos;
            col       <= '0;
            row       <= '0;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        S_ERASE, S_DRAW: begin
          if (scan_last) begin
            plot <= 1'b0;
            if (state == S_ERASE) state <= S_READ_KEY;
            else                  state <= won ? S_WIN : S_WAIT_TICK;
          end else begin
            col   <= col_nx;
            row   <= row_nx;
            pix_x <= xpos + X_W'(col_nx);
            pix_y <= ypos + Y_W'(row_nx);
          end
        end
        S_READ_KEY: begin
          if (key_ok) begin
            key_ack <= 1'b1;
            tgt_x   <= nx[X_W-1:0];
            tgt_y   <= ny[Y_W-1:0];
            tgt_ok  <= !off;
            obs_rd  <= !off;
            if (!off) begin
              obs_x <= nx[X_W-1:0];
              obs_y <= ny[Y_W-1:0];
            end
            state <= S_LOOK;
          end
        end
        S_LOOK: begin
          if (tgt_ok) begin
            wait_cnt <= '0;
            state    <= S_WAIT_OBS;
          end
        end
        S_WAIT_OBS: begin
          if (wait_done) begin
            if (!obs_blocked) state <= S_UPDATE_POS;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_UPDATE_POS: begin
          xpos  <= tgt_x;
          ypos  <= tgt_y;
          if (moves != 16'hFFFF) moves <= moves + 16'd1;
          state <= S_CHECK_WIN;
        end
        S_CHECK_WIN: begin
          if ((xpos == goal_x) && (ypos == goal_y)) won <= 1'b1;
        end
        S_WIN: ;
        default: state <= S_INIT;
      endcase
      if (go_draw) begin
        state     <= S_DRAW;
        plot      <= 1'b1;
        pix_color <= 1'b1;
        pix_x     <= xpos;
        pix_y     <= ypos;
        col       <= '0;
        row       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb/tb_maze_move_ctrl.sv - self-checking bench for maze_move_ctrl against a step-level model
module tb_maze_move_ctrl;

  localparam int X_W = 8, Y_W = 7, X_MAX = 159, Y_MAX = 119;
  localparam int SPRITE = 2, TICKS = 4, ML = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           key_valid = 1'b0;
  logic [2:0]     key_dir = 3'd0;
  logic           key_ack, obs_rd, obs_blocked, pix_color, plot, won;
  logic [X_W-1:0] obs_x, goal_x, xpos, pix_x;
  logic [Y_W-1:0] obs_y, goal_y, ypos, pix_y;
  logic [15:0]    moves;

  maze_move_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .START_X(0), .START_Y(0), .SPRITE(SPRITE), .TICKS(TICKS), .MEM_LAT(ML)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_dir(key_dir),
    .key_ack(key_ack), .obs_rd(obs_rd), .obs_x(obs_x), .obs_y(obs_y),
    .obs_blocked(obs_blocked), .goal_x(goal_x), .goal_y(goal_y),
    .xpos(xpos), .ypos(ypos), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .plot(plot), .moves(moves), .won(won)
  );

  always #5 clk = ~clk;

  // Obstacle memory: 16x16 tiled map, reply valid exactly ML=2 cycles after the
  // read strobe, random noise on every other cycle.
  bit blk[16][16];
  bit v0, d0;
  always @(posedge clk) begin
    v0          <= obs_rd;
    d0          <= blk[obs_x[3:0]][obs_y[3:0]];
    obs_blocked <= v0 ? d0 : 1'($urandom);
  end

  typedef struct {
    bit plot; bit color; int px; int py;
    bit ack; bit rd; int ox; int oy;
    bit kv; bit [2:0] kd;
    int ex; int ey; int mv; bit won;
    int tag;
  } rec_t;

  rec_t q[$];
  int   mx, my, mmoves, gx, gy;
  bit   mwon;
  int   checks = 0, failures = 0;
  int   cyc = 0, erase_cyc = 0, draw_cyc = 0;
  bit   erase_seen = 0, draw_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void push(bit p, bit c, int px, int py, bit ack, bit rd,
                               int ox, int oy, bit kv, bit [2:0] kd, int tag);
    rec_t r;
    r.plot = p; r.color = c; r.px = px; r.py = py;
    r.ack = ack; r.rd = rd; r.ox = ox; r.oy = oy;
    r.kv = kv; r.kd = kd;
    r.ex = mx; r.ey = my; r.mv = mmoves; r.won = mwon;
    r.tag = tag;
    q.push_back(r);
  endfunction

  function automatic void idle(bit kv, bit [2:0] kd);
    push(0, 0, 0, 0, 0, 0, 0, 0, kv, kd, 0);
  endfunction

  function automatic void sprite(bit color, bit kv, bit [2:0] kd);
    for (int r = 0; r < SPRITE; r++)
      for (int c = 0; c < SPRITE; c++)
        push(1, color, (mx + c) % (1 << X_W), (my + r) % (1 << Y_W),
             0, 0, 0, 0, kv, kd, color ? 0 : 1);
  endfunction

  // One game step described by its phases: wait, erase, key, lookup, move, redraw.
  function automatic void push_step(bit kv, bit [2:0] kd);
    int tx, ty;
    bit off;
    for (int i = 0; i < TICKS; i++) idle(kv, kd);
    sprite(0, kv, kd);
    idle(kv, kd);
    if (kv && kd >= 1 && kd <= 4) begin
      tx = mx; ty = my;
      case (kd)
        3'd1: tx = tx - 1;
        3'd2: tx = tx + 1;
        3'd3: ty = ty - 1;
        default: ty = ty + 1;
      endcase
      off = (tx < 0) || (tx > X_MAX) || (ty < 0) || (ty > Y_MAX);
`ifdef MAZE_WRAP_EN
      if (tx < 0) tx = X_MAX; else if (tx > X_MAX) tx = 0;
      if (ty < 0) ty = Y_MAX; else if (ty > Y_MAX) ty = 0;
      off = 0;
`endif
      push(0, 0, 0, 0, 1, !off, tx, ty, kv, kd, 0);
      if (!off) begin
        for (int i = 0; i < ML; i++) idle(0, 0);
        if (!blk[tx % 16][ty % 16]) begin
          idle(0, 0);
          mx = tx; my = ty;
          if (mmoves < 65535) mmoves++;
          idle(0, 0);
          if (mx == gx && my == gy) mwon = 1;
        end
      end
    end
    sprite(1, 0, 0);
  endfunction

  function automatic void model_init();
    mx = 0; my = 0; mmoves = 0; mwon = 0;
    q.delete();
    sprite(1, 0, 0);
  endfunction

  task automatic compare(input rec_t r);
    chk("plot", plot, r.plot);
    if (r.plot) begin
      chk("pix_color", pix_color, r.color);
      chk("pix_x", pix_x, r.px);
      chk("pix_y", pix_y, r.py);
    end
    chk("key_ack", key_ack, r.ack);
    chk("obs_rd", obs_rd, r.rd);
    if (r.rd) begin
      chk("obs_x", obs_x, r.ox);
      chk("obs_y", obs_y, r.oy);
    end
    chk("xpos", xpos, r.ex);
    chk("ypos", ypos, r.ey);
    chk("moves", moves, r.mv);
    chk("won", won, r.won);
    if (plot && !pix_color && !erase_seen) begin
      erase_seen = 1; erase_cyc = cyc;
    end else if (plot && pix_color && erase_seen && !draw_seen) begin
      draw_seen = 1; draw_cyc = cyc;
    end
  endtask

  // Walks the expected queue one cycle at a time; with stop_erase>0 it asserts
  // reset right after that many erase pixels have been seen.
  task automatic run_q(input int stop_erase);
    int   ne;
    rec_t r;
    ne = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      cyc++;
      r = q.pop_front();
      compare(r);
      key_valid = r.kv;
      key_dir   = r.kd;
      if (r.tag == 1) ne++;
      if (stop_erase != 0 && ne == stop_erase) begin
        reset = 1; key_valid = 0; key_dir = 0;
        q.delete();
      end
    end
  endtask

  task automatic finish_reset();
    @(negedge clk);
    cyc++;
    chk("rst_plot", plot, 0);
    chk("rst_key_ack", key_ack, 0);
    chk("rst_obs_rd", obs_rd, 0);
    chk("rst_obs_x", obs_x, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_moves", moves, 0);
    chk("rst_won", won, 0);
    reset = 0;
    model_init();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; key_valid = 0; key_dir = 0;
    finish_reset();
  endtask

  initial begin
    goal_x = 8'd80; goal_y = 7'd60; gx = 80; gy = 60;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) blk[i][j] = 0;
    blk[1][1] = 1;

    // Directed: right (clear), down (blocked), left, left at the edge.
    do_reset();
    erase_seen = 0; draw_seen = 0;
    push_step(1, 3'd2);
    push_step(1, 3'd4);
    push_step(1, 3'd1);
    push_step(1, 3'd1);
    run_q(0);
    chk("step_latency", draw_cyc - erase_cyc, 10);
`ifdef MAZE_WRAP_EN
    chk("lit_xpos", xpos, 159);
    chk("lit_moves", moves, 3);
`else
    chk("lit_xpos", xpos, 0);
    chk("lit_moves", moves, 2);
`endif
    chk("lit_ypos", ypos, 0);

    // Random walk over a random obstacle map, ending in a reset mid-erase.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) blk[i][j] = ($urandom_range(0, 3) == 0);
    do_reset();
    repeat (40) push_step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    run_q(0);
    push_step(1, 3'd2);
    run_q(2);
    finish_reset();
    run_q(0);

    // Goal one cell to the right: win, then keys are ignored.
    goal_x = 8'd1; goal_y = 7'd0; gx = 1; gy = 0;
    blk[1][0] = 0;
    do_reset();
    push_step(1, 3'd2);
    for (int i = 0; i < 12; i++) idle(1, 3'd2);
    run_q(0);
    chk("lit_won", won, 1);
    chk("lit_win_moves", moves, 1);
    chk("lit_win_xpos", xpos, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
